// File: rtl/mcdt_demux.sv
// mcdt_demux: splits the arbitrated MCDT stream back into three per-channel
// first-word-fall-through FIFOs, with sticky overflow / illegal-id flags and
// a saturating drop counter.
module mcdt_demux #(
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic [DW-1:0] mcdt_data_i,
    input  logic          mcdt_val_i,
    input  logic [1:0]    mcdt_id_i,

    output logic [DW-1:0] ch0_data_o,
    output logic          ch0_valid_o,
    input  logic          ch0_ready_i,
    output logic [CW-1:0] ch0_count_o,

    output logic [DW-1:0] ch1_data_o,
    output logic          ch1_valid_o,
    input  logic          ch1_ready_i,
    output logic [CW-1:0] ch1_count_o,

    output logic [DW-1:0] ch2_data_o,
    output logic          ch2_valid_o,
    input  logic          ch2_ready_i,
    output logic [CW-1:0] ch2_count_o,

    output logic [2:0]    ovf_o,
    output logic          id_err_o,
    output logic [7:0]    drop_cnt_o,
    input  logic          err_clr_i
);

    localparam int AW = $clog2(DEPTH);

    logic [2:0]           ready_w;
    logic [2:0]           pop_w;
    logic [2:0]           push_w;
    logic [2:0]           ovf_evt_w;
    logic                 id_evt_w;
    logic                 drop_evt_w;
    logic [2:0][DW-1:0]   head_w;
    logic [2:0][CW-1:0]   cnt_w;

    logic [2:0]           ovf_q,    ovf_d;
    logic                 id_err_q, id_err_d;
    logic [7:0]           drop_q,   drop_d;

    assign ready_w = {ch2_ready_i, ch1_ready_i, ch0_ready_i};

    for (genvar g = 0; g < 3; g++) begin : g_ch
        logic [DW-1:0] mem_q [DEPTH];
        logic [AW-1:0] wr_ptr_q;
        logic [AW-1:0] rd_ptr_q;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          hit_w;
        logic          full_w;

        assign hit_w        = mcdt_val_i && (mcdt_id_i == 2'(g));
        assign full_w       = (cnt_q == CW'(DEPTH));
        assign pop_w[g]     = (cnt_q != '0) && ready_w[g];
        // A full FIFO still accepts a word when its head leaves in the same cycle.
        assign push_w[g]    = hit_w && (!full_w || pop_w[g]);
        assign ovf_evt_w[g] = hit_w && full_w && !pop_w[g];

        assign head_w[g] = mem_q[rd_ptr_q];
        assign cnt_w[g]  = cnt_q;

        // Occupancy next-state from push/pop pair.
        always_comb begin
            cnt_d = cnt_q;
            case ({push_w[g], pop_w[g]})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        // Word storage; contents are meaningless while empty so no reset.
        always_ff @(posedge clk_i) begin
            if (push_w[g]) begin
                mem_q[wr_ptr_q] <= mcdt_data_i;
            end
        end

        // Pointers wrap naturally because DEPTH is a power of two.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (push_w[g]) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop_w[g])  rd_ptr_q <= rd_ptr_q + AW'(1);
                cnt_q <= cnt_d;
            end
        end
    end

    assign id_evt_w   = mcdt_val_i && (mcdt_id_i == 2'd3);
    assign drop_evt_w = id_evt_w || (|ovf_evt_w);

    // Error next-state: a clear pulse loses against an error in the same cycle.
    always_comb begin
        ovf_d    = ovf_q | ovf_evt_w;
        id_err_d = id_err_q | id_evt_w;
        drop_d   = drop_q;
        if (err_clr_i) begin
            ovf_d    = ovf_evt_w;
            id_err_d = id_evt_w;
            drop_d   = '0;
        end
        if (drop_evt_w) begin
            if (err_clr_i) begin
                drop_d = 8'd1;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    // Sticky error flags and saturating drop counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_q    <= '0;
            id_err_q <= 1'b0;
            drop_q   <= '0;
        end else begin
            ovf_q    <= ovf_d;
            id_err_q <= id_err_d;
            drop_q   <= drop_d;
        end
    end

    assign ch0_data_o  = head_w[0];
    assign ch1_data_o  = head_w[1];
    assign ch2_data_o  = head_w[2];
    assign ch0_count_o = cnt_w[0];
    assign ch1_count_o = cnt_w[1];
    assign ch2_count_o = cnt_w[2];
    assign ch0_valid_o = (cnt_w[0] != '0);
    assign ch1_valid_o = (cnt_w[1] != '0);
    assign ch2_valid_o = (cnt_w[2] != '0);

    assign ovf_o      = ovf_q;
    assign id_err_o   = id_err_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_mcdt_demux.sv
// tb_mcdt_demux: directed vector table plus hand-written multi-cycle
// sequences for the MCDT stream demultiplexer.
module tb_mcdt_demux;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [DW-1:0] mcdt_data_i;
    logic          mcdt_val_i;
    logic [1:0]    mcdt_id_i;
    logic [DW-1:0] ch0_data_o, ch1_data_o, ch2_data_o;
    logic          ch0_valid_o, ch1_valid_o, ch2_valid_o;
    logic          ch0_ready_i, ch1_ready_i, ch2_ready_i;
    logic [CW-1:0] ch0_count_o, ch1_count_o, ch2_count_o;
    logic [2:0]    ovf_o;
    logic          id_err_o;
    logic [7:0]    drop_cnt_o;
    logic          err_clr_i;

    int checks = 0;
    int errors = 0;

    mcdt_demux #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .mcdt_data_i (mcdt_data_i),
        .mcdt_val_i  (mcdt_val_i),
        .mcdt_id_i   (mcdt_id_i),
        .ch0_data_o  (ch0_data_o),
        .ch0_valid_o (ch0_valid_o),
        .ch0_ready_i (ch0_ready_i),
        .ch0_count_o (ch0_count_o),
        .ch1_data_o  (ch1_data_o),
        .ch1_valid_o (ch1_valid_o),
        .ch1_ready_i (ch1_ready_i),
        .ch1_count_o (ch1_count_o),
        .ch2_data_o  (ch2_data_o),
        .ch2_valid_o (ch2_valid_o),
        .ch2_ready_i (ch2_ready_i),
        .ch2_count_o (ch2_count_o),
        .ovf_o       (ovf_o),
        .id_err_o    (id_err_o),
        .drop_cnt_o  (drop_cnt_o),
        .err_clr_i   (err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    logic [DW-1:0] head [3];
    logic [2:0]    vld;
    int            cnt  [3];
    always_comb begin
        head[0] = ch0_data_o;
        head[1] = ch1_data_o;
        head[2] = ch2_data_o;
        vld     = {ch2_valid_o, ch1_valid_o, ch0_valid_o};
        cnt[0]  = int'(ch0_count_o);
        cnt[1]  = int'(ch1_count_o);
        cnt[2]  = int'(ch2_count_o);
    end

    typedef struct {
        logic        val;
        logic [1:0]  id;
        logic [31:0] data;
        logic [2:0]  rdy;
        logic        clr;
        int          c0, c1, c2;
        logic [2:0]  ovf;
        logic        iderr;
        int          drop;
        int          chk;     // channel whose head is checked, 3 = none
        logic [31:0] head;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic val, input logic [1:0] id, input logic [31:0] data,
                         input logic [2:0] rdy, input logic clr);
        mcdt_val_i  = val;
        mcdt_id_i   = id;
        mcdt_data_i = data;
        {ch2_ready_i, ch1_ready_i, ch0_ready_i} = rdy;
        err_clr_i   = clr;
    endtask

    task automatic check_counts(input string name, input int c0, input int c1, input int c2);
        check({name, " cnt0"}, 32'(cnt[0]), 32'(c0));
        check({name, " cnt1"}, 32'(cnt[1]), 32'(c1));
        check({name, " cnt2"}, 32'(cnt[2]), 32'(c2));
        check({name, " valid"}, {29'd0, vld}, {29'd0, c2 != 0, c1 != 0, c0 != 0});
    endtask

    task automatic check_err(input string name, input logic [2:0] ovf, input logic iderr, input int drop);
        check({name, " ovf"}, {29'd0, ovf_o}, {29'd0, ovf});
        check({name, " id_err"}, {31'd0, id_err_o}, {31'd0, iderr});
        check({name, " drop"}, {24'd0, drop_cnt_o}, 32'(drop));
    endtask

    initial begin
        int exp_idx [3];
        int sent;
        int cyc;

        tbl[0]  = '{1'b1, 2'd3, 32'hDEAD_BEEF, 3'b000, 1'b0, 0, 0, 0, 3'b000, 1'b1, 1, 3, 32'h0};
        tbl[1]  = '{1'b0, 2'd0, 32'h0,         3'b000, 1'b1, 0, 0, 0, 3'b000, 1'b0, 0, 3, 32'h0};
        tbl[2]  = '{1'b0, 2'd0, 32'h0000_1234, 3'b000, 1'b0, 0, 0, 0, 3'b000, 1'b0, 0, 3, 32'h0};
        tbl[3]  = '{1'b1, 2'd0, 32'h0000_00A0, 3'b000, 1'b0, 1, 0, 0, 3'b000, 1'b0, 0, 0, 32'h0000_00A0};
        tbl[4]  = '{1'b1, 2'd1, 32'h0000_00B0, 3'b000, 1'b0, 1, 1, 0, 3'b000, 1'b0, 0, 1, 32'h0000_00B0};
        tbl[5]  = '{1'b1, 2'd0, 32'h0000_00A1, 3'b000, 1'b0, 2, 1, 0, 3'b000, 1'b0, 0, 0, 32'h0000_00A0};
        tbl[6]  = '{1'b1, 2'd2, 32'h0000_00C0, 3'b001, 1'b0, 1, 1, 1, 3'b000, 1'b0, 0, 0, 32'h0000_00A1};
        tbl[7]  = '{1'b0, 2'd0, 32'h0,         3'b111, 1'b0, 0, 0, 0, 3'b000, 1'b0, 0, 3, 32'h0};
        tbl[8]  = '{1'b0, 2'd0, 32'h0,         3'b111, 1'b0, 0, 0, 0, 3'b000, 1'b0, 0, 3, 32'h0};
        tbl[9]  = '{1'b1, 2'd3, 32'h0,         3'b000, 1'b1, 0, 0, 0, 3'b000, 1'b1, 1, 3, 32'h0};
        tbl[10] = '{1'b1, 2'd1, 32'h0000_00B1, 3'b010, 1'b0, 0, 1, 0, 3'b000, 1'b1, 1, 1, 32'h0000_00B1};
        tbl[11] = '{1'b1, 2'd3, 32'h0,         3'b000, 1'b0, 0, 1, 0, 3'b000, 1'b1, 2, 1, 32'h0000_00B1};
        tbl[12] = '{1'b0, 2'd0, 32'h0,         3'b000, 1'b1, 0, 1, 0, 3'b000, 1'b0, 0, 1, 32'h0000_00B1};
        tbl[13] = '{1'b0, 2'd0, 32'h0,         3'b010, 1'b0, 0, 0, 0, 3'b000, 1'b0, 0, 3, 32'h0};

        rst_i = 1'b1;
        drive(1'b0, 2'd0, 32'h0, 3'b000, 1'b0);
        #2;
        check_counts("reset", 0, 0, 0);
        check_err("reset", 3'b000, 1'b0, 0);
        tick();
        rst_i = 1'b0;

        // Directed vector table: apply, clock, compare post-edge state.
        for (int i = 0; i < 14; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            drive(tbl[i].val, tbl[i].id, tbl[i].data, tbl[i].rdy, tbl[i].clr);
            tick();
            check_counts(nm, tbl[i].c0, tbl[i].c1, tbl[i].c2);
            check_err(nm, tbl[i].ovf, tbl[i].iderr, tbl[i].drop);
            if (tbl[i].chk < 3) check({nm, " head"}, head[tbl[i].chk], tbl[i].head);
        end
        drive(1'b0, 2'd0, 32'h0, 3'b000, 1'b0);

        // Streaming through ch0 with ready held high: one word per cycle.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'd0, 32'h00C0_0000 + 32'(i), 3'b001, 1'b0);
            tick();
            check($sformatf("stream0 head%0d", i), head[0], 32'h00C0_0000 + 32'(i));
            check($sformatf("stream0 cnt%0d", i), 32'(cnt[0]), 32'd1);
        end
        drive(1'b0, 2'd0, 32'h0, 3'b001, 1'b0);
        tick();
        check_counts("stream0 end", 0, 0, 0);
        check_err("stream0 end", 3'b000, 1'b0, 0);

        // Overflow on ch1, then drain.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'd1, 32'h00C1_0000 + 32'(i), 3'b000, 1'b0);
            tick();
            check($sformatf("ovf1 cnt%0d", i), 32'(cnt[1]), (i < 8) ? 32'(i + 1) : 32'd8);
        end
        drive(1'b0, 2'd0, 32'h0, 3'b010, 1'b0);
        check_err("ovf1", 3'b010, 1'b0, 2);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain1 head%0d", i), head[1], 32'h00C1_0000 + 32'(i));
            check($sformatf("drain1 valid%0d", i), {31'd0, vld[1]}, 32'd1);
            tick();
        end
        check_counts("drain1 end", 0, 0, 0);
        drive(1'b0, 2'd0, 32'h0, 3'b000, 1'b1);
        tick();
        err_clr_i = 1'b0;
        check_err("clr1", 3'b000, 1'b0, 0);

        // Full ch2 with simultaneous push and pop.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'd2, 32'h00C2_0000 + 32'(i), 3'b000, 1'b0);
            tick();
        end
        check("full2 cnt", 32'(cnt[2]), 32'd8);
        drive(1'b1, 2'd2, 32'h00C2_0008, 3'b100, 1'b0);
        tick();
        check("full2 pp cnt", 32'(cnt[2]), 32'd8);
        check_err("full2 pp", 3'b000, 1'b0, 0);
        drive(1'b0, 2'd0, 32'h0, 3'b100, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("drain2 head%0d", i), head[2], 32'h00C2_0000 + 32'(i));
            tick();
        end
        check_counts("drain2 end", 0, 0, 0);

        // Drop counter saturation and error-beats-clear.
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 2'd3, 32'h0, 3'b000, 1'b0);
            tick();
        end
        check_err("sat", 3'b000, 1'b1, 255);
        drive(1'b1, 2'd3, 32'h0, 3'b000, 1'b1);
        tick();
        check_err("clr+err", 3'b000, 1'b1, 1);
        drive(1'b0, 2'd0, 32'h0, 3'b000, 1'b1);
        tick();
        check_err("clr2", 3'b000, 1'b0, 0);

        // Interleaved ids with random per-channel ready.
        exp_idx = '{0, 0, 0};
        sent = 0;
        cyc  = 0;
        drive(1'b0, 2'd0, 32'h0, 3'b000, 1'b0);
        while ((exp_idx[0] < 10 || exp_idx[1] < 10 || exp_idx[2] < 10 || sent < 30) && cyc < 400) begin
            if (sent < 30) begin
                mcdt_val_i  = 1'b1;
                mcdt_id_i   = 2'(sent % 3);
                mcdt_data_i = 32'h00F0_0000 | (32'(sent % 3) << 16) | 32'(sent / 3);
                sent++;
            end else begin
                mcdt_val_i = 1'b0;
            end
            ch0_ready_i = ($urandom_range(0, 3) != 0);
            ch1_ready_i = ($urandom_range(0, 3) != 0);
            ch2_ready_i = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < 3; c++) begin
                logic rdy_c;
                rdy_c = (c == 0) ? ch0_ready_i : (c == 1) ? ch1_ready_i : ch2_ready_i;
                if (vld[c] && rdy_c) begin
                    check($sformatf("mix ch%0d word%0d", c, exp_idx[c]), head[c],
                          32'h00F0_0000 | (32'(c) << 16) | 32'(exp_idx[c]));
                    exp_idx[c]++;
                end
            end
            tick();
            cyc++;
        end
        for (int c = 0; c < 3; c++) begin
            check($sformatf("mix ch%0d total", c), 32'(exp_idx[c]), 32'd10);
        end
        drive(1'b0, 2'd0, 32'h0, 3'b000, 1'b0);
        check_counts("mix end", 0, 0, 0);
        check_err("mix end", 3'b000, 1'b0, 0);

        // Asynchronous reset mid-burst.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'd0, 32'h00D0_0000 + 32'(i), 3'b000, 1'b0);
            tick();
        end
        check("prerst cnt0", 32'(cnt[0]), 32'd5);
        mcdt_data_i = 32'h00D0_0005;
        #3;
        rst_i = 1'b1;
        #1;
        check_counts("async rst", 0, 0, 0);
        check_err("async rst", 3'b000, 1'b0, 0);
        tick();
        check_counts("rst held", 0, 0, 0);
        drive(1'b1, 2'd0, 32'h00E0_0000, 3'b000, 1'b0);
        #2;
        rst_i = 1'b0;
        tick();
        check("postrst cnt0", 32'(cnt[0]), 32'd1);
        check("postrst head0", head[0], 32'h00E0_0000);
        drive(1'b1, 2'd0, 32'h00E0_0001, 3'b001, 1'b0);
        tick();
        check("postrst head1", head[0], 32'h00E0_0001);
        drive(1'b0, 2'd0, 32'h0, 3'b001, 1'b0);
        tick();
        check_counts("postrst end", 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
